y86_pc_stat_ctrl: RTL and testbench

//  Owns the architectural PC and the Y86-64 status register (AOK/HLT/ADR/INS) for the processor

---
 rtl/y86_pkg.sv | 17 +
 rtl/y86_sat_counter.sv | 34 +++
 rtl/y86_pc_stat_ctrl.sv | 141 ++++++++++++++
 tb/tb_y86_pc_stat_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 core definitions: status codes and the PC/stat controller FSM encoding.
package y86_pkg;

    localparam int STAT_W = 3;

    localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
    localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
    localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
    localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/y86_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module y86_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en && !(&q_q)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/y86_pc_stat_ctrl.sv
// Architectural PC and status register with run/stop sequencing and performance counters.
module y86_pc_stat_ctrl
    import y86_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic              stall,
    input  logic              retire,
    input  logic              instr_valid,
    input  logic              imem_error,
    input  logic              dmem_error,
    input  logic              halt_instr,
    input  logic [ADDR_W-1:0] pc_next,
    output logic [ADDR_W-1:0] pc,
    output logic [STAT_W-1:0] stat,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
);

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [STAT_W-1:0] stat_q, stat_d;
    logic              running_q, running_d;
    logic              done_q, done_d;

    logic              fault;
    logic [STAT_W-1:0] fault_stat;
    logic              cyc_inc;
    logic              instr_inc;

    // Fault priority: a bad fetch address hides everything decoded from it.
    always_comb begin
        fault      = 1'b1;
        fault_stat = STAT_AOK;
        if (imem_error) begin
            fault_stat = STAT_ADR;
        end else if (!instr_valid) begin
            fault_stat = STAT_INS;
        end else if (dmem_error) begin
            fault_stat = STAT_ADR;
        end else if (halt_instr) begin
            fault_stat = STAT_HLT;
        end else begin
            fault = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stat_d    = stat_q;
        done_d    = 1'b0;
        cyc_inc   = 1'b0;
        instr_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cyc_inc = 1'b1;
                if (retire && !stall) begin
                    if (fault) begin
                        // PC stays on the faulting instruction; only HALT counts as retired.
                        stat_d    = fault_stat;
                        state_d   = ST_STOP;
                        done_d    = 1'b1;
                        instr_inc = (fault_stat == STAT_HLT);
                    end else begin
                        pc_d      = pc_next;
                        instr_inc = 1'b1;
                    end
                end
            end
            ST_STOP: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear) begin
            state_d   = ST_IDLE;
            pc_d      = RESET_PC;
            stat_d    = STAT_AOK;
            done_d    = 1'b0;
            cyc_inc   = 1'b0;
            instr_inc = 1'b0;
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            stat_q    <= STAT_AOK;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            stat_q    <= stat_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    y86_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cyc_inc),
        .clr   (clear),
        .q     (cycle_cnt)
    );

    y86_sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (instr_inc),
        .clr   (clear),
        .q     (instr_cnt)
    );

    assign pc      = pc_q;
    assign stat    = stat_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_y86_pc_stat_ctrl.sv
// Directed bench: a default-width instance and a CNT_W=4 / RESET_PC=0x100 instance share stimulus.
module tb_y86_pc_stat_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, clear, stall, retire, instr_valid;
    logic        imem_error, dmem_error, halt_instr;
    logic [63:0] pc_next;

    logic [63:0] pc_a, pc_b;
    logic [2:0]  stat_a, stat_b;
    logic        running_a, running_b, done_a, done_b;
    logic [31:0] cyc_a, ins_a;
    logic [3:0]  cyc_b, ins_b;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    y86_pc_stat_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .stall(stall),
        .retire(retire), .instr_valid(instr_valid), .imem_error(imem_error),
        .dmem_error(dmem_error), .halt_instr(halt_instr), .pc_next(pc_next),
        .pc(pc_a), .stat(stat_a), .running(running_a), .done(done_a),
        .cycle_cnt(cyc_a), .instr_cnt(ins_a)
    );

    y86_pc_stat_ctrl #(.ADDR_W(64), .RESET_PC(64'h100), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .stall(stall),
        .retire(retire), .instr_valid(instr_valid), .imem_error(imem_error),
        .dmem_error(dmem_error), .halt_instr(halt_instr), .pc_next(pc_next),
        .pc(pc_b), .stat(stat_b), .running(running_b), .done(done_b),
        .cycle_cnt(cyc_b), .instr_cnt(ins_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        start = 0; clear = 0; stall = 0; retire = 0; instr_valid = 1;
        imem_error = 0; dmem_error = 0; halt_instr = 0; pc_next = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        quiet();
        rst_n = 1'b0;
        #12;
        chk("rst_pc", pc_a, 64'h0);
        chk("rst_pc_b", pc_b, 64'h100);
        chk("rst_stat", stat_a, 3'd1);
        chk("rst_running", running_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_cyc", cyc_a, 0);
        chk("rst_ins", ins_a, 0);
        rst_n = 1'b1;

        step(); step();
        chk("idle_cyc", cyc_a, 0);
        chk("idle_running", running_a, 0);

        start = 1; step(); start = 0;
        chk("start_running", running_a, 1);
        chk("start_cyc", cyc_a, 0);

        for (int i = 1; i <= 4; i++) begin
            retire = 1; pc_next = 64'(10 * i);
            step();
            chk("commit_pc", pc_a, 64'(10 * i));
        end
        chk("commit_ins", ins_a, 4);
        chk("commit_cyc", cyc_a, 4);
        chk("commit_stat", stat_a, 3'd1);

        stall = 1; retire = 1; halt_instr = 1; pc_next = 64'h99;
        step(); step(); step();
        chk("stall_pc", pc_a, 64'h28);
        chk("stall_cyc", cyc_a, 7);
        chk("stall_ins", ins_a, 4);
        chk("stall_stat", stat_a, 3'd1);
        chk("stall_done", done_a, 0);

        quiet(); imem_error = 1;
        step();
        chk("noretire_stat", stat_a, 3'd1);
        chk("noretire_pc", pc_a, 64'h28);

        quiet(); retire = 1; halt_instr = 1; pc_next = 64'h32;
        step();
        chk("halt_stat", stat_a, 3'd2);
        chk("halt_pc", pc_a, 64'h28);
        chk("halt_done", done_a, 1);
        chk("halt_running", running_a, 0);
        chk("halt_ins", ins_a, 5);
        chk("halt_cyc", cyc_a, 9);

        quiet(); start = 1; retire = 1; pc_next = 64'h77;
        step();
        chk("stop_done", done_a, 0);
        chk("stop_running", running_a, 0);
        chk("stop_stat", stat_a, 3'd2);
        chk("stop_pc", pc_a, 64'h28);
        chk("stop_cyc", cyc_a, 9);

        quiet(); clear = 1;
        step();
        chk("clr_pc", pc_a, 64'h0);
        chk("clr_pc_b", pc_b, 64'h100);
        chk("clr_stat", stat_a, 3'd1);
        chk("clr_cyc", cyc_a, 0);
        chk("clr_ins", ins_a, 0);

        start = 1; clear = 1;
        step();
        chk("startclr_running", running_a, 0);

        quiet(); start = 1; step(); start = 0;
        chk("run2", running_a, 1);
        retire = 1; imem_error = 1; instr_valid = 0; pc_next = 64'h50;
        step();
        chk("adr_stat", stat_a, 3'd3);
        chk("adr_pc", pc_a, 64'h0);
        chk("adr_pc_b", pc_b, 64'h100);
        chk("adr_done", done_a, 1);
        chk("adr_ins", ins_a, 0);
        chk("adr_cyc", cyc_a, 1);

        quiet(); clear = 1; step();
        quiet(); start = 1; step();
        quiet(); retire = 1; instr_valid = 0; dmem_error = 1;
        step();
        chk("ins_stat", stat_a, 3'd4);

        quiet(); clear = 1; step();
        quiet(); start = 1; step();
        quiet(); retire = 1; dmem_error = 1; halt_instr = 1;
        step();
        chk("dmem_stat", stat_a, 3'd3);
        chk("dmem_ins", ins_a, 0);

        quiet(); clear = 1; step();
        quiet(); start = 1; step();
        quiet(); retire = 1; halt_instr = 1; clear = 1;
        step();
        chk("fltclr_done", done_a, 0);
        chk("fltclr_stat", stat_a, 3'd1);
        chk("fltclr_running", running_a, 0);

        quiet(); start = 1; step(); start = 0;
        for (int i = 0; i < 20; i++) begin
            retire = 1; pc_next = 64'(8 * i);
            step();
        end
        chk("sat_cyc_b", cyc_b, 4'd15);
        chk("sat_ins_b", ins_b, 4'd15);
        chk("sat_cyc_a", cyc_a, 20);
        chk("sat_ins_a", ins_a, 20);
        chk("sat_pc_b", pc_b, 64'd152);
        quiet(); step();
        chk("sat_hold_b", cyc_b, 4'd15);

        clear = 1; step(); clear = 0;
        chk("satclr_cyc_b", cyc_b, 0);
        chk("satclr_ins_b", ins_b, 0);
        chk("satclr_pc_b", pc_b, 64'h100);

        start = 1; step(); start = 0;
        retire = 1; pc_next = 64'h44; step();
        chk("prereset_pc", pc_a, 64'h44);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pc", pc_a, 64'h0);
        chk("async_running", running_a, 0);
        chk("async_cyc", cyc_a, 0);
        chk("async_ins", ins_a, 0);
        chk("async_stat", stat_a, 3'd1);
        quiet();
        #3;
        rst_n = 1'b1;
        step();
        chk("postrst_running", running_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
